// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: op encodings, FSM states,
// default prescale and the per-quarter pad drive table.
package i2c_pkg;

  typedef enum logic [1:0] {
    I2C_START = 2'd0,
    I2C_WRITE = 2'd1,
    I2C_READ  = 2'd2,
    I2C_STOP  = 2'd3
  } i2c_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } i2c_state_t;

  localparam int QDIV_DEFAULT = 10;
  localparam logic [3:0] ACK_BIT = 4'd8;

  // {scl_oe, sda_oe} for quarter q of an op; d is the SDA drive of the current bit
  function automatic logic [1:0] quarter_drive(i2c_mode_t op, logic [1:0] q, logic d);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      I2C_START: begin
        case (q)
          2'd0, 2'd1: r = 2'b00;
          2'd2:       r = 2'b01;
          default:    r = 2'b11;
        endcase
      end
      I2C_STOP: begin
        case (q)
          2'd0:       r = 2'b11;
          2'd1, 2'd2: r = 2'b01;
          default:    r = 2'b00;
        endcase
      end
      default: r = {(q == 2'd0) || (q == 2'd3), d};
    endcase
    return r;
  endfunction

  // SDA pull-down for bit b of a byte op: data bits on WRITE, ACK slot on READ
  function automatic logic bit_drive(i2c_mode_t op, logic [3:0] b, logic msb, logic ack);
    logic r;
    r = 1'b0;
    if (op == I2C_WRITE && b < ACK_BIT)
      r = ~msb;
    else if (op == I2C_READ && b == ACK_BIT)
      r = ack;
    return r;
  endfunction

endpackage

// File: rtl/i2c_if.sv
// Host-side request/response and pad signals of the I2C master.
// The master modport is the core's view; slave is the host/pad side.
interface i2c_if import i2c_pkg::*; ();

  logic       start;
  i2c_mode_t  mode;
  logic [7:0] tx_data;
  logic       ack_in;
  logic       done;
  logic       busy;
  logic [7:0] rx_data;
  logic       ack_out;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    input  start, mode, tx_data, ack_in, sda_i,
    output done, busy, rx_data, ack_out, scl_oe, sda_oe
  );

  modport slave (
    output start, mode, tx_data, ack_in, sda_i,
    input  done, busy, rx_data, ack_out, scl_oe, sda_oe
  );

endinterface

// File: rtl/i2c_qtick.sv
// Quarter-SCL-period prescaler: tick is high on the last cycle of each
// QDIV-cycle phase; restart realigns the phase to the following cycle.
module i2c_qtick #(
  parameter int QDIV = 10
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(QDIV);
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: one START, WRITE, READ or STOP per accepted request,
// driving open-drain SCL/SDA enables in quarter-period steps.
module i2c_master import i2c_pkg::*; #(
  parameter int QDIV = QDIV_DEFAULT
) (
  input  logic   sys_clk,
  input  logic   sys_rst,
  i2c_if.master  bus
);

  i2c_state_t state;
  i2c_mode_t  op;
  logic [1:0] qidx;
  logic [3:0] bidx;
  logic [7:0] sreg;
  logic       ack_l;

  logic       tick;
  logic       accept;
  logic       byte_op;
  logic       last_q;
  logic       smp;
  logic [3:0] nb;
  logic       nd;

  assign accept = (state != RUN) && bus.start;

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (accept),
    .tick    (tick)
  );

  assign byte_op = (op == I2C_WRITE) || (op == I2C_READ);
  assign last_q  = (qidx == 2'd3) && (!byte_op || bidx == ACK_BIT);
  // An undriven or unknown pad reads as released, i.e. NACK / data 1
  assign smp     = (bus.sda_i === 1'b0) ? 1'b0 : 1'b1;
  assign nb      = (qidx == 2'd3) ? bidx + 4'd1 : bidx;
  assign nd      = (qidx == 2'd3) ? bit_drive(op, nb, sreg[7], ack_l) : bus.sda_oe;

  // sreg serves both directions: WRITE shifts its MSB out, READ shifts samples in
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      op          <= I2C_START;
      qidx        <= '0;
      bidx        <= '0;
      sreg        <= '0;
      ack_l       <= 1'b0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.rx_data <= '0;
      bus.ack_out <= 1'b0;
      bus.scl_oe  <= 1'b0;
      bus.sda_oe  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        RUN: begin
          if (tick) begin
            if (last_q) begin
              state    <= DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              if (op == I2C_READ)
                bus.rx_data <= sreg;
            end else begin
              qidx <= qidx + 2'd1;
              bidx <= nb;
              {bus.scl_oe, bus.sda_oe} <= quarter_drive(op, qidx + 2'd1, nd);
              if (byte_op && qidx == 2'd2) begin
                if (bidx < ACK_BIT)
                  sreg <= {sreg[6:0], smp};
                else if (op == I2C_WRITE)
                  bus.ack_out <= ~smp;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          if (bus.start) begin
            state    <= RUN;
            op       <= bus.mode;
            sreg     <= bus.tx_data;
            ack_l    <= bus.ack_in;
            qidx     <= '0;
            bidx     <= '0;
            bus.busy <= 1'b1;
            {bus.scl_oe, bus.sda_oe} <= quarter_drive(bus.mode, 2'd0,
                bit_drive(bus.mode, 4'd0, bus.tx_data[7], bus.ack_in));
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed + randomized bench for i2c_master with an open-drain bus and a
// behavioural slave; expectations come from the I2C framing rules.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int QDIV = 10;

  logic sys_clk = 1'b0;
  logic sys_rst;
  i2c_if bus ();

  i2c_master #(.QDIV(QDIV)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Slave behaviour: 1 = write target (ACKs if slave_ack), 2 = read source
  logic [1:0] slave_mode = 2'd0;
  logic       slave_ack  = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  int fall_base = 0;
  int fall_cnt  = 0;
  int start_cnt = 0;
  int stop_cnt  = 0;
  logic seen_bits[$];

  logic scl_line, sda_line, slave_pull;
  int   bit_no;

  function automatic logic slave_level(logic [1:0] sm, logic sa, logic [7:0] sb, int b);
    if (sm == 2'd1)
      return sa && (b == 8);
    if (sm == 2'd2 && b >= 0 && b < 8)
      return ((sb << b) & 8'h80) == 8'h00;
    return 1'b0;
  endfunction

  assign scl_line   = ~bus.scl_oe;
  assign bit_no     = fall_cnt - fall_base;
  assign slave_pull = slave_level(slave_mode, slave_ack, slave_byte, bit_no);
  assign sda_line   = ~(bus.sda_oe | slave_pull);
  assign bus.sda_i  = sda_line;

  always @(negedge scl_line) fall_cnt = fall_cnt + 1;
  always @(posedge scl_line) seen_bits.push_back(sda_line);
  always @(negedge sda_line) if (scl_line === 1'b1) start_cnt = start_cnt + 1;
  always @(posedge sda_line) if (scl_line === 1'b1) stop_cnt = stop_cnt + 1;

  // Each bit or frame is 4 quarters of QDIV cycles; a byte is 8 data bits + ACK
  function automatic int op_cycles(i2c_mode_t m);
    int frames;
    frames = (m == I2C_WRITE || m == I2C_READ) ? 9 : 1;
    return frames * 4 * QDIV;
  endfunction

  function automatic logic [8:0] collect(int base);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < 9; i++)
      v = {v[7:0], (base + i < seen_bits.size()) ? seen_bits[base + i] : 1'b0};
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input i2c_mode_t m, input logic [7:0] d, input logic a, output int lat);
    int t0;
    @(negedge sys_clk);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.tx_data = d;
    bus.ack_in  = a;
    @(posedge sys_clk); #1;
    checkOutput("busy_after_accept", bus.busy, 1);
    t0 = cyc;
    bus.start   = 1'b0;
    bus.mode    = i2c_mode_t'($urandom_range(0, 3));
    bus.tx_data = 8'($urandom);
    bus.ack_in  = 1'($urandom);
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge sys_clk); #1;
      if (bus.done === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    checkOutput("busy_at_done", bus.busy, 0);
  endtask

  task automatic doFrame(input i2c_mode_t m);
    int lat, s0, p0;
    s0 = start_cnt;
    p0 = stop_cnt;
    applyStimulus(m, 8'($urandom), 1'($urandom), lat);
    checkOutput("frame_latency", lat, op_cycles(m));
    checkOutput("start_conditions", start_cnt - s0, (m == I2C_START) ? 1 : 0);
    checkOutput("stop_conditions", stop_cnt - p0, (m == I2C_STOP) ? 1 : 0);
    checkOutput("bus_after_frame", {bus.scl_oe, bus.sda_oe}, (m == I2C_START) ? 2'b11 : 2'b00);
  endtask

  task automatic doWrite(input logic [7:0] d, input logic ack);
    int lat, sb;
    slave_mode = 2'd1;
    slave_ack  = ack;
    fall_base  = fall_cnt;
    sb = seen_bits.size();
    applyStimulus(I2C_WRITE, d, 1'b0, lat);
    checkOutput("write_latency", lat, op_cycles(I2C_WRITE));
    checkOutput("write_ack_out", bus.ack_out, ack);
    checkOutput("write_scl_pulses", seen_bits.size() - sb, 9);
    checkOutput("write_bus_bits", collect(sb), {d, ~ack});
    checkOutput("write_scl_low_after", bus.scl_oe, 1);
    slave_mode = 2'd0;
  endtask

  task automatic doRead(input logic [7:0] b, input logic ack);
    int lat, sb;
    slave_mode = 2'd2;
    slave_byte = b;
    fall_base  = fall_cnt;
    sb = seen_bits.size();
    applyStimulus(I2C_READ, 8'($urandom), ack, lat);
    checkOutput("read_latency", lat, op_cycles(I2C_READ));
    checkOutput("read_rx_data", bus.rx_data, b);
    checkOutput("read_scl_pulses", seen_bits.size() - sb, 9);
    checkOutput("read_bus_bits", collect(sb), {b, ~ack});
    slave_mode = 2'd0;
  endtask

  initial begin
    int stamps[3];
    int n, t0, done_seen;

    sys_rst     = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = I2C_START;
    bus.tx_data = 8'h00;
    bus.ack_in  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      checkOutput("reset_scl_oe", bus.scl_oe, 0);
      checkOutput("reset_sda_oe", bus.sda_oe, 0);
      checkOutput("reset_done", bus.done, 0);
      checkOutput("reset_busy", bus.busy, 0);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    checkOutput("reset_rx_data", bus.rx_data, 0);
    checkOutput("reset_ack_out", bus.ack_out, 0);

    doFrame(I2C_START);
    doWrite(8'hA5, 1'b1);
    doWrite(8'hA5, 1'b0);
    doRead(8'h3C, 1'b0);
    doFrame(I2C_STOP);

    for (int r = 0; r < 4; r++) begin
      doFrame(I2C_START);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 1) == 0)
          doWrite(8'($urandom), 1'($urandom));
        else
          doRead(8'($urandom), 1'($urandom));
      end
      doFrame(I2C_STOP);
    end

    // start held high: writes chain with one idle cycle between them
    doFrame(I2C_START);
    slave_mode = 2'd1;
    slave_ack  = 1'b1;
    fall_base  = fall_cnt;
    @(negedge sys_clk);
    bus.start   = 1'b1;
    bus.mode    = I2C_WRITE;
    bus.tx_data = 8'($urandom);
    @(posedge sys_clk); #1;
    t0 = cyc;
    n  = 0;
    for (int i = 0; i < 1500 && n < 3; i++) begin
      @(posedge sys_clk); #1;
      if (bus.done === 1'b1) begin
        stamps[n] = cyc;
        n++;
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b_done_count", n, 3);
    checkOutput("b2b_first_done", stamps[0] - t0, op_cycles(I2C_WRITE));
    checkOutput("b2b_interval_1", stamps[1] - stamps[0], op_cycles(I2C_WRITE) + 1);
    checkOutput("b2b_interval_2", stamps[2] - stamps[1], op_cycles(I2C_WRITE) + 1);
    @(posedge sys_clk); #1;
    checkOutput("b2b_stopped", bus.busy, 0);
    slave_mode = 2'd0;
    doFrame(I2C_STOP);

    // reset in the middle of a byte aborts without a done pulse
    doFrame(I2C_START);
    @(negedge sys_clk);
    bus.start   = 1'b1;
    bus.mode    = I2C_WRITE;
    bus.tx_data = 8'($urandom);
    @(posedge sys_clk); #1;
    bus.start = 1'b0;
    repeat (100) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    checkOutput("abort_scl_oe", bus.scl_oe, 0);
    checkOutput("abort_sda_oe", bus.sda_oe, 0);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge sys_clk); #1;
      if (bus.done === 1'b1) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    checkOutput("abort_idle_bus", {bus.scl_oe, bus.sda_oe}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
